// File: rtl/conv5x5_mac_ctrl_if.sv
// Stream/handshake bundle for conv5x5_mac_ctrl: start request, pixel/weight
// input stream and saturated result output stream.
// Optional macro CONV_SAT_FLAG_EN adds the o_sat clamp indicator.
interface conv5x5_mac_ctrl_if #(
    parameter int DW  = 8,
    parameter int WW  = 8,
    parameter int O_W = 16
) ();
    logic           i_start;
    logic           o_busy;
    logic           i_valid;
    logic           o_ready;
    logic [DW-1:0]  i_pix;
    logic [WW-1:0]  i_wgt;
    logic           o_valid;
    logic           i_ready;
    logic [O_W-1:0] o_data;
`ifdef CONV_SAT_FLAG_EN
    logic           o_sat;
`endif

    // Master is the surrounding datapath (fetch side and writer side).
    modport master (
        output i_start, i_valid, i_pix, i_wgt, i_ready,
`ifdef CONV_SAT_FLAG_EN
        input  o_sat,
`endif
        input  o_busy, o_ready, o_valid, o_data
    );

    // Slave is the MAC sequencer itself.
    modport slave (
        input  i_start, i_valid, i_pix, i_wgt, i_ready,
`ifdef CONV_SAT_FLAG_EN
        output o_sat,
`endif
        output o_busy, o_ready, o_valid, o_data
    );
endinterface

// File: rtl/conv5x5_mac_ctrl.sv
// Sequencer for one 5x5 convolution output: on start, accumulates K signed
// pixel*weight products, clamps the sum to O_W bits and hands it downstream
// over a valid/ready handshake.
// Optional macro CONV_SAT_FLAG_EN adds the registered o_sat clamp flag.
module conv5x5_mac_ctrl #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int K     = 25,
    parameter int ACC_W = 21,
    parameter int O_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    conv5x5_mac_ctrl_if.slave bus
);
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int PW    = DW + WW;

    // Clamp thresholds expressed at accumulator width so the compare is
    // a full-width signed compare.
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-O_W+1){1'b0}}, {(O_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-O_W+1){1'b1}}, {(O_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [O_W-1:0]          data_q;
    logic                    valid_q;
`ifdef CONV_SAT_FLAG_EN
    logic                    sat_q;
`endif

    logic                    accept;
    logic                    last_accept;
    logic                    out_done;
    logic signed [PW-1:0]    pix_ext;
    logic signed [PW-1:0]    wgt_ext;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;

    // Full-precision signed product, sign-extended to the accumulator.
    assign pix_ext     = {{WW{bus.i_pix[DW-1]}}, bus.i_pix};
    assign wgt_ext     = {{DW{bus.i_wgt[WW-1]}}, bus.i_wgt};
    assign prod        = pix_ext * wgt_ext;
    assign prod_ext    = {{(ACC_W-PW){prod[PW-1]}}, prod};

    assign accept      = (state == ACCUM) && bus.i_valid;
    assign last_accept = accept && (cnt == LAST_TAP);
    assign out_done    = (state == OUT) && bus.i_ready;

    // State register; reset aborts whatever window is in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.i_start) next_state = ACCUM;
            ACCUM:   if (last_accept) next_state = SAT;
            SAT:     next_state = OUT;
            OUT:     if (bus.i_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs; ready depends on state only, never on i_valid.
    always_comb begin
        bus.o_ready = (state == ACCUM);
        bus.o_busy  = (state != IDLE);
    end

    // Accumulator, tap counter and the registered result/valid pair.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef CONV_SAT_FLAG_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) && bus.i_start) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= acc + prod_ext;
                cnt <= last_accept ? '0 : cnt + 1'b1;
            end

            if (state == SAT) begin
                valid_q <= 1'b1;
                if (acc >= SAT_HI) begin
                    data_q <= SAT_HI[O_W-1:0];
                end else if (acc <= SAT_LO) begin
                    data_q <= SAT_LO[O_W-1:0];
                end else begin
                    data_q <= acc[O_W-1:0];
                end
`ifdef CONV_SAT_FLAG_EN
                sat_q <= (acc >= SAT_HI) || (acc <= SAT_LO);
`endif
            end else if (out_done) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
`ifdef CONV_SAT_FLAG_EN
    assign bus.o_sat   = sat_q;
`endif

endmodule

// File: tb/tb_conv5x5_mac_ctrl.sv
// Self-checking bench for conv5x5_mac_ctrl: directed windows from the test
// plan plus randomized windows, checked against a plain sum-and-clamp model.
// Build with +define+CONV_SAT_FLAG_EN to also check o_sat.
module tb_conv5x5_mac_ctrl;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int K     = 25;
    localparam int ACC_W = 21;
    localparam int O_W   = 16;
    localparam int OMAX  = 32767;
    localparam int OMIN  = -32768;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    int pix_q[$];
    int wgt_q[$];

    conv5x5_mac_ctrl_if #(.DW(DW), .WW(WW), .O_W(O_W)) bus ();

    conv5x5_mac_ctrl #(
        .DW(DW), .WW(WW), .K(K), .ACC_W(ACC_W), .O_W(O_W)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int s);
        if (s >= OMAX) return OMAX;
        if (s <= OMIN) return OMIN;
        return s;
    endfunction

    function automatic bit clamped(input int s);
        return (s >= OMAX) || (s <= OMIN);
    endfunction

    function automatic void fill_const(input int p, input int w);
        pix_q.delete();
        wgt_q.delete();
        for (int i = 0; i < K; i++) begin
            pix_q.push_back(p);
            wgt_q.push_back(w);
        end
    endfunction

    // Runs one full window from start to output handshake using pix_q/wgt_q.
    task automatic apply_stimulus(input string tag, input int gap_pct, input int ready_wait);
        int sum;
        int exp_data;
        int gaps;
        sum = 0;
        foreach (pix_q[i]) sum += pix_q[i] * wgt_q[i];
        exp_data = clamp(sum);

        check_output({tag, " idle busy"}, 32'(bus.o_busy), 0);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check_output({tag, " busy after start"}, 32'(bus.o_busy), 1);

        foreach (pix_q[i]) begin
            gaps = 0;
            while (gaps < 3 && int'($urandom_range(99)) < gap_pct) begin
                bus.i_valid = 1'b0;
                bus.i_start = 1'($urandom_range(1));
                bus.i_pix   = 8'($urandom);
                bus.i_wgt   = 8'($urandom);
                tick();
                gaps++;
            end
            bus.i_start = 1'b0;
            check_output({tag, " ready in accum"}, 32'(bus.o_ready), 1);
            bus.i_valid = 1'b1;
            bus.i_pix   = 8'(pix_q[i]);
            bus.i_wgt   = 8'(wgt_q[i]);
            tick();
        end
        bus.i_valid = 1'b0;

        check_output({tag, " ready after last"}, 32'(bus.o_ready), 0);
        check_output({tag, " valid 1 cycle after last"}, 32'(bus.o_valid), 0);
        bus.i_ready = (ready_wait == 0);
        tick();
        check_output({tag, " valid 2 cycles after last"}, 32'(bus.o_valid), 1);
        check_output({tag, " data"}, $signed(bus.o_data), exp_data);
`ifdef CONV_SAT_FLAG_EN
        check_output({tag, " sat"}, 32'(bus.o_sat), 32'(clamped(sum)));
`endif

        for (int w = 0; w < ready_wait; w++) begin
            bus.i_ready = 1'b0;
            bus.i_start = 1'b1;
            tick();
            check_output({tag, " valid held"}, 32'(bus.o_valid), 1);
            check_output({tag, " data held"}, $signed(bus.o_data), exp_data);
        end

        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check_output({tag, " valid drop"}, 32'(bus.o_valid), 0);
        check_output({tag, " busy drop"}, 32'(bus.o_busy), 0);
        check_output({tag, " data kept"}, $signed(bus.o_data), exp_data);
        tick();
        check_output({tag, " start in handshake ignored"}, 32'(bus.o_busy), 0);
    endtask

    // Directed and randomized sequence.
    initial begin
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_pix   = '0;
        bus.i_wgt   = '0;
        bus.i_ready = 1'b0;

        i_rst = 1'b1;
        tick();
        tick();
        check_output("reset busy", 32'(bus.o_busy), 0);
        check_output("reset ready", 32'(bus.o_ready), 0);
        check_output("reset valid", 32'(bus.o_valid), 0);
        check_output("reset data", $signed(bus.o_data), 0);
`ifdef CONV_SAT_FLAG_EN
        check_output("reset sat", 32'(bus.o_sat), 0);
`endif
        i_rst = 1'b0;
        tick();

        $display("[TB] unit taps");
        fill_const(1, 1);
        apply_stimulus("unit", 0, 0);

        $display("[TB] clamps");
        fill_const(127, 127);
        apply_stimulus("pos clamp", 0, 0);
        fill_const(-128, -128);
        apply_stimulus("pos clamp neg*neg", 0, 1);
        fill_const(-128, 127);
        apply_stimulus("neg clamp", 0, 0);

        $display("[TB] boundaries");
        fill_const(0, 5);
        pix_q[0] = 127; wgt_q[0] = 127;
        pix_q[1] = 127; wgt_q[1] = 127;
        pix_q[2] = 127; wgt_q[2] = 4;
        pix_q[3] = 1;   wgt_q[3] = 1;
        apply_stimulus("exact max", 0, 0);
        pix_q[3] = 0;
        apply_stimulus("max minus 1", 0, 0);
        pix_q[3] = 2;
        apply_stimulus("max plus 1", 0, 0);
        fill_const(0, -7);
        pix_q[0] = -128; wgt_q[0] = 127;
        pix_q[1] = -128; wgt_q[1] = 127;
        pix_q[2] = -128; wgt_q[2] = 2;
        apply_stimulus("exact min", 0, 0);
        pix_q[3] = 1; wgt_q[3] = 1;
        apply_stimulus("min plus 1", 0, 0);
        pix_q[3] = -1;
        apply_stimulus("min minus 1", 0, 0);

        $display("[TB] stalls");
        fill_const(2, 3);
        apply_stimulus("stall", 60, 5);

        $display("[TB] mid-run reset");
        fill_const(100, 100);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_valid = 1'b1;
            bus.i_pix   = 8'(pix_q[i]);
            bus.i_wgt   = 8'(wgt_q[i]);
            tick();
        end
        bus.i_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        check_output("abort busy", 32'(bus.o_busy), 0);
        check_output("abort ready", 32'(bus.o_ready), 0);
        check_output("abort valid", 32'(bus.o_valid), 0);
        i_rst = 1'b0;
        tick();
        fill_const(1, -1);
        apply_stimulus("after abort", 0, 0);

        $display("[TB] randomized windows");
        for (int n = 0; n < 16; n++) begin
            int mode;
            mode = int'($urandom_range(2));
            pix_q.delete();
            wgt_q.delete();
            for (int i = 0; i < K; i++) begin
                if (mode == 0) begin
                    pix_q.push_back(int'($urandom_range(255)) - 128);
                    wgt_q.push_back(int'($urandom_range(255)) - 128);
                end else if (mode == 1) begin
                    pix_q.push_back(int'($urandom_range(31)) - 16);
                    wgt_q.push_back(int'($urandom_range(31)) - 16);
                end else begin
                    pix_q.push_back(int'($urandom_range(127)) - 20);
                    wgt_q.push_back(int'($urandom_range(127)) - 20);
                end
            end
            apply_stimulus($sformatf("rand%0d", n), int'($urandom_range(50)),
                           int'($urandom_range(4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
